rv32_wb_arbiter: RTL

Writeback-side driver of the rv32 register file write port. Merges the in-order pipeline writeback with results from a long-latency unit (divider/load miss) through a valid/ready buffer. Keeps a per-register pending scoreboard so decode stalls on RAW/WAW hazards against outstanding long-latency results. Outputs feed the register file's `rd_in`, `rd_write_in`, `rd_value_in` and `writeback_flush_in` directly.

---
 rtl/rv32_wb_pkg.sv | 14 +
 rtl/rv32_wb_fifo.sv | 64 ++++++
 rtl/rv32_wb_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/rv32_wb_pkg.sv
// Shared types and widths for the rv32 writeback arbiter slice.
package rv32_wb_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32'(1) << REG_W;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  value;
  } wb_req_t;

endpackage

// File: rtl/rv32_wb_fifo.sv
// Synchronous FIFO of writeback requests with registered full/empty flags.
module rv32_wb_fifo
  import rv32_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head_c,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_c  = mem[rd_ptr];

  // Occupancy after this edge; drives the registered flags.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage needs no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rv32_wb_arbiter.sv
// Register-file write port driver: merges pipeline writeback with buffered
// long-latency results and tracks outstanding long-latency destinations.
module rv32_wb_arbiter
  import rv32_wb_pkg::*;
#(
  parameter int unsigned LU_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_in,
  input  logic             pipe_valid_in,
  input  logic [REG_W-1:0] pipe_rd_in,
  input  logic             pipe_rd_write_in,
  input  logic [XLEN-1:0]  pipe_rd_value_in,
  input  logic             issue_valid_in,
  input  logic [REG_W-1:0] issue_rd_in,
  input  logic             lu_valid_in,
  input  logic [REG_W-1:0] lu_rd_in,
  input  logic [XLEN-1:0]  lu_value_in,
  output logic             lu_ready_out,
  input  logic [REG_W-1:0] rs1_in,
  input  logic [REG_W-1:0] rs2_in,
  output logic             hazard_stall_out,
  output logic [REG_W-1:0] rd_out,
  output logic             rd_write_out,
  output logic [XLEN-1:0]  rd_value_out,
  output logic             writeback_flush_out
);

  wb_req_t          push_data;
  wb_req_t          head_c;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             pipe_wr;
  logic             out_lu;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;
  logic             out_hold;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             issue_hit;

  assign lu_ready_out = !fifo_full;
  assign push         = lu_valid_in && lu_ready_out;
  assign push_data    = '{rd: lu_rd_in, value: lu_value_in};
  assign pipe_wr      = pipe_valid_in && pipe_rd_write_in && (|pipe_rd_in) && !flush_in;
  assign pop          = !pipe_wr && !fifo_empty;

  rv32_wb_fifo #(
    .DEPTH(LU_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head_c   (head_c),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Output register: pipeline write wins, otherwise drain one buffered result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_out              <= '0;
      rd_write_out        <= 1'b0;
      rd_value_out        <= '0;
      out_lu              <= 1'b0;
      writeback_flush_out <= 1'b0;
    end else begin
      writeback_flush_out <= flush_in;
      if (pipe_wr) begin
        rd_out       <= pipe_rd_in;
        rd_write_out <= 1'b1;
        rd_value_out <= pipe_rd_value_in;
        out_lu       <= 1'b0;
      end else if (pop) begin
        rd_out       <= head_c.rd;
        rd_write_out <= |head_c.rd;
        rd_value_out <= head_c.value;
        out_lu       <= 1'b1;
      end else begin
        rd_write_out <= 1'b0;
        out_lu       <= 1'b0;
      end
    end
  end

  // Scoreboard update; a same-edge issue overrides the pop clear.
  always_comb begin
    pending_next = pending;
    if (pop && (head_c.rd != '0)) pending_next[head_c.rd] = 1'b0;
    if (issue_valid_in && (issue_rd_in != '0)) pending_next[issue_rd_in] = 1'b1;
  end

  // Scoreboard register; x0 is never marked.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Stall decode on outstanding results, including one still in the output register.
  always_comb begin
    out_hold  = rd_write_out && out_lu;
    rs1_hit   = (rs1_in != '0) && (pending[rs1_in] || (out_hold && (rd_out == rs1_in)));
    rs2_hit   = (rs2_in != '0) && (pending[rs2_in] || (out_hold && (rd_out == rs2_in)));
    issue_hit = (issue_rd_in != '0) &&
                (pending[issue_rd_in] || (out_hold && (rd_out == issue_rd_in)));
    hazard_stall_out = rs1_hit || rs2_hit || (issue_valid_in && issue_hit);
  end

endmodule
